// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t  : access sequencer states (IDLE, ISSUE, WAIT, DONE)
//   arb_owner_t  : which pipeline port owns the current access
//   ARB_CNT_LEN  : width of the latency timer (covers latencies 1..15)
//   latency_load : value loaded into the timer for a given memory latency
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ARB_CNT_LEN = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_DM = 1'b0,
        ARB_OWNER_IF = 1'b1
    } arb_owner_t;

    // The timer counts down to zero inclusive, so a latency of N needs N-1
    // loaded; zero is then reached in the cycle the read data is valid.
    function automatic logic [ARB_CNT_LEN-1:0] latency_load(input int latency);
        return ARB_CNT_LEN'(latency - 1);
    endfunction

endpackage

// File: rtl/arb_latency_timer.sv
// -----------------------------------------------------------------------------
// arb_latency_timer
// Small load/decrement down-counter with a zero flag, intended for any unit
// that has to wait a fixed number of cycles on a multi-cycle resource.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (count -> 0)
//   load       in   load load_value this cycle (has priority over dec)
//   load_value in   W-bit value to load
//   dec        in   decrement by one; holds at zero
//   zero       out  count is zero
// -----------------------------------------------------------------------------
module arb_latency_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrementing stops at zero so a stray dec
    // can never wrap the counter around.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch port
// (read-only) and the data-memory port (read/write) of the 5-stage pipeline.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE.
// DM has fixed priority over IF; the stall outputs feed the pipeline freeze.
//
// Optional build macro: ARB_STALL_CNT_EN adds IF_STALL_CYCLES, a saturating
// count of cycles IF spent stalled behind DM or behind a busy memory.
//
// Ports:
//   CLK, RESET                clock and synchronous active-high reset
//   IF_REQ/IF_ADDR            fetch request (held until IF_READY)
//   IF_RDATA/IF_READY         fetched word and one-cycle completion pulse
//   IF_STALL                  IF_REQ & ~IF_READY
//   DM_REQ/DM_WE/DM_ADDR/     data request (held until DM_READY)
//   DM_WDATA
//   DM_RDATA/DM_READY         load data and one-cycle completion pulse
//   DM_STALL                  DM_REQ & ~DM_READY
//   MEM_EN/MEM_WE/MEM_ADDR/   memory strobe (one cycle per access) and the
//   MEM_WDATA                 registered command fields
//   MEM_RDATA                 read data, valid MEM_LATENCY cycles after MEM_EN
//   IF_STALL_CYCLES           (ARB_STALL_CNT_EN only) CNT_W-bit stall count
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [DATA_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_READY,
    output logic              IF_STALL,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [DATA_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    output logic [DATA_W-1:0] DM_RDATA,
    output logic              DM_READY,
    output logic              DM_STALL,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  IF_STALL_CYCLES
`endif
);

    arb_state_t state;
    arb_state_t next_state;
    arb_owner_t owner;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_zero;
    logic       capture_rdata;

    // Waits out the memory latency; zero marks the cycle MEM_RDATA is valid.
    arb_latency_timer #(
        .W (ARB_CNT_LEN)
    ) u_timer (
        .clk        (CLK),
        .reset      (RESET),
        .load       (timer_load),
        .load_value (latency_load(MEM_LATENCY)),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer: one access at a time, each visiting every state once. A
    // latency of one gives a single WAIT cycle because the timer is loaded
    // with zero in ISSUE.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (DM_REQ || IF_REQ) begin
                    next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                timer_load = 1'b1;
                next_state = ARB_WAIT;
            end
            ARB_WAIT: begin
                timer_dec = 1'b1;
                if (timer_zero) begin
                    next_state = ARB_DONE;
                end
            end
            ARB_DONE: begin
                next_state = ARB_IDLE;
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Request capture happens only in IDLE, so the command presented to the
    // memory stays stable for the whole access even if the requester changes
    // or drops its inputs. DM wins a tie; IF never writes, and its accesses
    // leave MEM_WDATA at whatever DM last stored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner     <= ARB_OWNER_DM;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else if (state == ARB_IDLE) begin
            if (DM_REQ) begin
                owner     <= ARB_OWNER_DM;
                MEM_WE    <= DM_WE;
                MEM_ADDR  <= DM_ADDR;
                MEM_WDATA <= DM_WDATA;
            end else if (IF_REQ) begin
                owner     <= ARB_OWNER_IF;
                MEM_WE    <= 1'b0;
                MEM_ADDR  <= IF_ADDR;
            end
        end
    end

    assign capture_rdata = (state == ARB_WAIT) && timer_zero && !MEM_WE;

    // Only the owner's read register moves, and only on a read; writes and
    // the idle port keep the last word they were handed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            IF_RDATA <= '0;
            DM_RDATA <= '0;
        end else if (capture_rdata) begin
            if (owner == ARB_OWNER_IF) begin
                IF_RDATA <= MEM_RDATA;
            end else begin
                DM_RDATA <= MEM_RDATA;
            end
        end
    end

    assign MEM_EN   = (state == ARB_ISSUE);
    assign IF_READY = (state == ARB_DONE) && (owner == ARB_OWNER_IF);
    assign DM_READY = (state == ARB_DONE) && (owner == ARB_OWNER_DM);
    assign IF_STALL = IF_REQ & ~IF_READY;
    assign DM_STALL = DM_REQ & ~DM_READY;

`ifdef ARB_STALL_CNT_EN
    // Counts fetch stall cycles caused by the arbiter: IF waiting behind DM
    // or behind an access already in flight. Sticks at all ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            IF_STALL_CYCLES <= '0;
        end else if (IF_STALL && ((owner == ARB_OWNER_DM) || (state != ARB_IDLE))
                     && (IF_STALL_CYCLES != '1)) begin
            IF_STALL_CYCLES <= IF_STALL_CYCLES + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives mem_port_arbiter against a latency-accurate memory model. A driver
// issues directed and random transactions and pushes the expected memory
// command and port responses into queues; a monitor pops and compares them
// whenever the DUT strobes the memory or pulses a READY.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DATA_W = 32;
    localparam int LAT    = 2;
    localparam int CNT_W  = 16;

    logic              CLK      = 1'b0;
    logic              RESET    = 1'b1;
    logic              IF_REQ   = 1'b0;
    logic [DATA_W-1:0] IF_ADDR  = '0;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_READY;
    logic              IF_STALL;
    logic              DM_REQ   = 1'b0;
    logic              DM_WE    = 1'b0;
    logic [DATA_W-1:0] DM_ADDR  = '0;
    logic [DATA_W-1:0] DM_WDATA = '0;
    logic [DATA_W-1:0] DM_RDATA;
    logic              DM_READY;
    logic              DM_STALL;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA = '0;
`ifdef ARB_STALL_CNT_EN
    logic [CNT_W-1:0]  IF_STALL_CYCLES;
`endif

    mem_port_arbiter #(
        .DATA_W      (DATA_W),
        .MEM_LATENCY (LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_RDATA  (IF_RDATA),
        .IF_READY  (IF_READY),
        .IF_STALL  (IF_STALL),
        .DM_REQ    (DM_REQ),
        .DM_WE     (DM_WE),
        .DM_ADDR   (DM_ADDR),
        .DM_WDATA  (DM_WDATA),
        .DM_RDATA  (DM_RDATA),
        .DM_READY  (DM_READY),
        .DM_STALL  (DM_STALL),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA)
`ifdef ARB_STALL_CNT_EN
        ,
        .IF_STALL_CYCLES (IF_STALL_CYCLES)
`endif
    );

    always #5 CLK = ~CLK;

    // Cycle number: increments on each rising edge, so cycle c spans the
    // interval from rising edge c to rising edge c+1.
    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    resp_t if_q[$];
    resp_t dm_q[$];
    acc_t  mem_q[$];

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dm_last = '0;
    logic [31:0] if_hold = '0;
    logic [31:0] dm_hold = '0;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    // External memory: writes land when strobed, reads appear only during
    // the cycle MEM_LATENCY after the strobe; any other cycle carries noise.
    int          rd_due = -1;
    logic [31:0] rd_val = '0;
    always @(negedge CLK) begin
        if (MEM_EN === 1'b1) begin
            if (MEM_WE) begin
                mem[MEM_ADDR] = MEM_WDATA;
            end else begin
                rd_due = cyc + LAT;
                rd_val = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'h0;
            end
        end
        if (cyc == rd_due) begin
            MEM_RDATA = rd_val;
        end else begin
            MEM_RDATA = $urandom;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected memory command on every strobe and the
    // expected response on every READY; RDATA must only change on READY.
    always @(negedge CLK) begin
        resp_t r;
        acc_t  a;
        if (mon_on) begin
            if (IF_READY) begin
                if (if_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL if_ready_spurious: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = if_q.pop_front();
                    checkOutput("if_ready_cycle", cyc, r.cyc);
                    checkOutput("if_rdata", IF_RDATA, r.data);
                    if_hold = r.data;
                end
            end else begin
                checkOutput("if_rdata_hold", IF_RDATA, if_hold);
            end
            if (DM_READY) begin
                if (dm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL dm_ready_spurious: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = dm_q.pop_front();
                    checkOutput("dm_ready_cycle", cyc, r.cyc);
                    checkOutput("dm_rdata", DM_RDATA, r.data);
                    dm_hold = r.data;
                end
            end else begin
                checkOutput("dm_rdata_hold", DM_RDATA, dm_hold);
            end
            if (MEM_EN) begin
                if (mem_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL mem_en_spurious: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    a = mem_q.pop_front();
                    checkOutput("mem_en_cycle", cyc, a.cyc);
                    checkOutput("mem_addr", MEM_ADDR, a.addr);
                    checkOutput("mem_we", {31'd0, MEM_WE}, {31'd0, a.we});
                    if (a.we) begin
                        checkOutput("mem_wdata", MEM_WDATA, a.wdata);
                    end
                end
            end
            checkOutput("if_stall", {31'd0, IF_STALL}, {31'd0, IF_REQ & ~IF_READY});
            checkOutput("dm_stall", {31'd0, DM_STALL}, {31'd0, DM_REQ & ~DM_READY});
        end
    end

    // Issues one transaction while the arbiter is idle. kind 0 = IF only,
    // 1 = DM only, 2 = both together. Expected timing follows the access
    // rules: a lone request completes LAT+2 cycles after it is raised, and
    // in a tie IF starts LAT+3 cycles after DM. Returns one cycle after the
    // last READY, with both requests low.
    task automatic applyStimulus(input int kind, input logic [31:0] if_addr,
                                 input logic dm_we, input logic [31:0] dm_addr,
                                 input logic [31:0] dm_wdata, input bit drop_early);
        int t;
        int if_start;
        int guard;
        bit if_pend;
        bit dm_pend;
        bit if_seen;
        bit dm_seen;
        t       = cyc;
        if_pend = (kind != 1);
        dm_pend = (kind != 0);
        if (dm_pend) begin
            DM_REQ   = 1'b1;
            DM_WE    = dm_we;
            DM_ADDR  = dm_addr;
            DM_WDATA = dm_wdata;
            mem_q.push_back('{t + 1, dm_we, dm_addr, dm_wdata});
            if (dm_we) begin
                ref_mem[dm_addr] = dm_wdata;
            end else begin
                dm_last = ref_mem[dm_addr];
            end
            dm_q.push_back('{t + LAT + 2, dm_last});
        end
        if (if_pend) begin
            if_start = dm_pend ? t + LAT + 3 : t;
            IF_REQ   = 1'b1;
            IF_ADDR  = if_addr;
            mem_q.push_back('{if_start + 1, 1'b0, if_addr, 32'h0});
            if_q.push_back('{if_start + LAT + 2, ref_mem[if_addr]});
        end
        guard = 0;
        while ((if_pend || dm_pend) && guard < 4 * LAT + 20) begin
            @(negedge CLK);
            if_seen = IF_READY;
            dm_seen = DM_READY;
            @(posedge CLK);
            #1;
            if (if_seen && if_pend) begin
                IF_REQ  = 1'b0;
                if_pend = 1'b0;
            end
            if (dm_seen && dm_pend) begin
                DM_REQ  = 1'b0;
                dm_pend = 1'b0;
            end
            if (drop_early && kind != 2 && cyc == t + 1) begin
                IF_REQ = 1'b0;
                DM_REQ = 1'b0;
            end
            guard++;
        end
        if (if_pend || dm_pend) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: got no READY expected READY (kind %0d, start %0d)",
                     kind, t);
            IF_REQ = 1'b0;
            DM_REQ = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        int          gap;
        logic [31:0] a_if;
        logic [31:0] a_dm;
        logic [31:0] wd;
        logic        we;
        bit          drop;
        int          t;
`ifdef ARB_STALL_CNT_EN
        logic [CNT_W-1:0] cnt_before;
`endif
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            mem[32'(i * 4)]     = wd;
            ref_mem[32'(i * 4)] = wd;
        end
        mem[32'h10]     = 32'hDEADBEEF;
        ref_mem[32'h10] = 32'hDEADBEEF;

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_if_ready", {31'd0, IF_READY}, 32'd0);
        checkOutput("rst_dm_ready", {31'd0, DM_READY}, 32'd0);
        checkOutput("rst_if_rdata", IF_RDATA, 32'd0);
        checkOutput("rst_dm_rdata", DM_RDATA, 32'd0);
        checkOutput("rst_mem_en", {31'd0, MEM_EN}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        checkOutput("rst_mem_addr", MEM_ADDR, 32'd0);
        checkOutput("rst_mem_wdata", MEM_WDATA, 32'd0);
        mon_on = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] fetch read of 0x10");
        applyStimulus(0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("[TB] DM write then read-back of 0x20");
        applyStimulus(1, 32'h0, 1'b1, 32'h20, 32'h12345678, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, 32'h20, 32'h0, 1'b0);

        $display("[TB] simultaneous DM read 0x10 and IF read 0x14");
`ifdef ARB_STALL_CNT_EN
        cnt_before = IF_STALL_CYCLES;
`endif
        applyStimulus(2, 32'h14, 1'b0, 32'h10, 32'h0, 1'b0);
`ifdef ARB_STALL_CNT_EN
        checkOutput("if_stall_cycles", 32'(IF_STALL_CYCLES - cnt_before), 32'(2 * LAT + 5));
`endif

        $display("[TB] back-to-back fetches 0x10 then 0x14");
        applyStimulus(0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(0, 32'h14, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("[TB] reset during WAIT");
        t       = cyc;
        DM_REQ  = 1'b1;
        DM_WE   = 1'b0;
        DM_ADDR = 32'h10;
        mem_q.push_back('{t + 1, 1'b0, 32'h10, 32'h0});
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET  = 1'b1;
        DM_REQ = 1'b0;
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        if_hold = '0;
        dm_hold = '0;
        dm_last = '0;
        checkOutput("rst_mid_mem_en", {31'd0, MEM_EN}, 32'd0);
        checkOutput("rst_mid_dm_ready", {31'd0, DM_READY}, 32'd0);
        checkOutput("rst_mid_dm_rdata", DM_RDATA, 32'd0);
        checkOutput("rst_mid_if_rdata", IF_RDATA, 32'd0);
        repeat (LAT + 3) @(posedge CLK);
        #1;
        applyStimulus(1, 32'h0, 1'b0, 32'h10, 32'h0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a_if = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            a_dm = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            drop = ($urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, 2);
            applyStimulus(kind, a_if, we, a_dm, wd, drop);
            repeat (gap) begin
                @(posedge CLK);
                #1;
            end
        end

        repeat (LAT + 6) @(posedge CLK);
        #1;
        checkOutput("if_q_drained", 32'(if_q.size()), 32'd0);
        checkOutput("dm_q_drained", 32'(dm_q.size()), 32'd0);
        checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
